sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port 32-bit arbiter in front of a 16-bit SRAM driver; splits words into halfwords, does byte RMW.
// Optional round-robin arbitration under `define SRAM_ARB_RR_EN (default: port 0 has fixed priority).
module sram_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_valid,
  input  logic        p1_valid,
  output logic        p0_ready,
  output logic        p1_ready,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [17:0] p0_addr,
  input  logic [17:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p0_wstrb,
  input  logic [3:0]  p1_wstrb,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        ph_q, ph_d, rmw_q, rmw_d, port_q, port_d, we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [15:0] lo_q, lo_d;
  logic        mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        p0_ready_q, p0_ready_d, p1_ready_q, p1_ready_d;
  logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic        grant, leg_go, leg_ph, resp_go;
  logic [1:0]  pair;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;
  assign grant = (p0_valid && p1_valid) ? ~last_q : ~p0_valid;
`else
  assign grant = ~p0_valid;
`endif

  function automatic logic [15:0] merge_half(input logic [1:0] en, input logic [15:0] wd,
                                             input logic [15:0] rd);
    return {en[1] ? wd[15:8] : rd[15:8], en[0] ? wd[7:0] : rd[7:0]};
  endfunction

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    rmw_d       = rmw_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    lo_d        = lo_q;
    mem_valid_d = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_ready_d  = 1'b0;
    p1_ready_d  = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    leg_go      = 1'b0;
    leg_ph      = 1'b0;
    resp_go     = 1'b0;
    pair        = 2'b00;
`ifdef SRAM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (p0_valid || p1_valid) begin
          port_d  = grant;
          we_d    = grant ? p1_we    : p0_we;
          addr_d  = grant ? p1_addr  : p0_addr;
          wdata_d = grant ? p1_wdata : p0_wdata;
          wstrb_d = grant ? p1_wstrb : p0_wstrb;
          leg_go  = 1'b1;
          leg_ph  = we_d && (wstrb_d[1:0] == 2'b00);
`ifdef SRAM_ARB_RR_EN
          last_d  = grant;
`endif
        end
      end
      // A write whose strobes are all zero arrives here with no command and goes straight to RESP.
      ISSUE: begin
        if (mem_valid_q) state_d = WAIT;
        else             resp_go = 1'b1;
      end
      WAIT: begin
        if (mem_ready) begin
          if (rmw_q) begin
            // Merged halfword becomes a full-strobe write of the same halfword.
            if (ph_q) begin
              wdata_d[31:16] = merge_half(wstrb_q[3:2], wdata_q[31:16], mem_rdata);
              wstrb_d[3:2]   = 2'b11;
            end else begin
              wdata_d[15:0]  = merge_half(wstrb_q[1:0], wdata_q[15:0], mem_rdata);
              wstrb_d[1:0]   = 2'b11;
            end
            leg_go = 1'b1;
            leg_ph = ph_q;
          end else if (!we_q && !ph_q) begin
            lo_d   = mem_rdata;
            leg_go = 1'b1;
            leg_ph = 1'b1;
          end else if (we_q && !ph_q && (wstrb_q[3:2] != 2'b00)) begin
            leg_go = 1'b1;
            leg_ph = 1'b1;
          end else begin
            resp_go = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (leg_go) begin
      state_d     = ISSUE;
      ph_d        = leg_ph;
      pair        = leg_ph ? wstrb_d[3:2] : wstrb_d[1:0];
      rmw_d       = we_d && (pair == 2'b01 || pair == 2'b10);
      mem_valid_d = !(we_d && pair == 2'b00);
      mem_we_d    = we_d && !rmw_d;
      mem_addr_d  = {addr_d, leg_ph};
      mem_wdata_d = leg_ph ? wdata_d[31:16] : wdata_d[15:0];
    end

    if (resp_go) begin
      state_d = RESP;
      if (port_q) begin
        p1_ready_d = 1'b1;
        if (!we_q) p1_rdata_d = {mem_rdata, lo_q};
      end else begin
        p0_ready_d = 1'b1;
        if (!we_q) p0_rdata_d = {mem_rdata, lo_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ph_q        <= 1'b0;
      rmw_q       <= 1'b0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lo_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      rmw_q       <= rmw_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      lo_q        <= lo_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_ready_q  <= p0_ready_d;
      p1_ready_q  <= p1_ready_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
`ifdef SRAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign p0_ready  = p0_ready_q;
  assign p1_ready  = p1_ready_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: 3-cycle SRAM driver model, response and command queues.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p0_valid, p1_valid, p0_ready, p1_ready, p0_we, p1_we;
  logic [17:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        mem_valid, mem_ready, mem_we;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  sram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_we(p0_we), .p1_we(p1_we), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int port; logic [31:0] rdata; int start; int lat; } resp_t;
  typedef struct { logic we; logic [18:0] addr; logic [15:0] wdata; } cmd_t;
  resp_t resp_q[$];
  cmd_t  cmd_q[$];
  resp_t mon_e;
  cmd_t  drv_c;
  bit    chk_cmd = 1'b1;
  logic [15:0] mem [0:255];
  logic [15:0] rd_hold = 16'h0;
  int    pend = 0, pulses = 0, p_base = 0;
  logic  prev_valid = 1'b0, prev_r0 = 1'b0, prev_r1 = 1'b0;
  int    tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [18:0] addr, input logic [15:0] wdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    cmd_q.push_back(c);
  endtask

  task automatic push_resp(input int port, input logic [31:0] rdata, input int lat);
    resp_t r;
    r.port = port; r.rdata = rdata; r.start = cyc; r.lat = lat;
    resp_q.push_back(r);
  endtask

  // Raise valid, hold until the port's ready is seen, optionally drop it.
  task automatic req(input int port, input logic we, input logic [17:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb, input bit drop);
    int  n;
    logic seen;
    if (port == 0) begin
      p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
    end else begin
      p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk); #1;
      n++;
      seen = (port == 0) ? p0_ready : p1_ready;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL req_timeout: port %0d got no ready within %0d cycles", port, n);
    end
    if (drop) begin
      if (port == 0) p0_valid = 1'b0; else p1_valid = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  // SRAM driver model: mem_ready three cycles after the mem_valid cycle.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 16'hCCCC;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = 16'hCCCC;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin mem_ready = 1'b1; mem_rdata = rd_hold; end
      end
      if (mem_valid) begin
        chk("mem_valid_pulse_while_busy", 32'(prev_valid || pend > 0 || mem_ready), 32'h0);
        pulses++;
        if (chk_cmd) begin
          if (cmd_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_cmd: we %0d addr %h, none expected", mem_we, mem_addr);
          end else begin
            drv_c = cmd_q.pop_front();
            chk("cmd_we", 32'(mem_we), 32'(drv_c.we));
            chk("cmd_addr", 32'(mem_addr), 32'(drv_c.addr));
            if (drv_c.we) chk("cmd_wdata", 32'(mem_wdata), 32'(drv_c.wdata));
          end
        end
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
        else        rd_hold = mem[mem_addr[7:0]];
        pend = 3;
      end
      prev_valid = mem_valid;
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (p0_ready || p1_ready) begin
        chk("ready_exclusive", 32'(p0_ready & p1_ready), 32'h0);
        chk("ready_pulse_width", 32'((p0_ready & prev_r0) | (p1_ready & prev_r1)), 32'h0);
        if (resp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ready: p0_ready %0d p1_ready %0d, none expected", p0_ready, p1_ready);
        end else begin
          mon_e = resp_q.pop_front();
          chk("resp_port", 32'(p1_ready), 32'(mon_e.port));
          chk("resp_rdata", p1_ready ? p1_rdata : p0_rdata, mon_e.rdata);
          if (mon_e.lat >= 0) chk("resp_latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
        end
      end
      prev_r0 = p0_ready;
      prev_r1 = p1_ready;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_p0_ready"}, 32'(p0_ready), 32'h0);
    chk({tag, "_p1_ready"}, 32'(p1_ready), 32'h0);
    chk({tag, "_p0_rdata"}, p0_rdata, 32'h0);
    chk({tag, "_p1_rdata"}, p1_rdata, 32'h0);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h0;
    resetn = 1'b0;
    p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
    idle_cycles(3);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    idle_cycles(2);

    // 1: 32-bit read, low halfword first
    mem[8'h20] = 16'hBEEF; mem[8'h21] = 16'hDEAD;
    push_cmd(1'b0, 19'h00020, 16'h0);
    push_cmd(1'b0, 19'h00021, 16'h0);
    push_resp(0, 32'hDEADBEEF, 9);
    p_base = pulses;
    req(0, 1'b0, 18'h00010, 32'h0, 4'h0, 1'b1);
    chk("read_pulses", 32'(pulses - p_base), 32'd2);
    idle_cycles(3);

    // 2: full write from port 1; its rdata holds the reset value
    push_cmd(1'b1, 19'h00006, 16'h5678);
    push_cmd(1'b1, 19'h00007, 16'h1234);
    push_resp(1, 32'h0, 9);
    p_base = pulses;
    req(1, 1'b1, 18'h00003, 32'h12345678, 4'b1111, 1'b1);
    chk("wr_full_pulses", 32'(pulses - p_base), 32'd2);
    chk("wr_full_mem_lo", 32'(mem[8'h06]), 32'h5678);
    chk("wr_full_mem_hi", 32'(mem[8'h07]), 32'h1234);
    idle_cycles(3);

    // 3: single-byte write -> RMW on the low halfword only
    mem[8'h00] = 16'h1122; mem[8'h01] = 16'h3344;
    push_cmd(1'b0, 19'h00000, 16'h0);
    push_cmd(1'b1, 19'h00000, 16'hAB22);
    push_resp(0, 32'hDEADBEEF, 9);
    p_base = pulses;
    req(0, 1'b1, 18'h00000, 32'h0000AB00, 4'b0010, 1'b1);
    chk("rmw_pulses", 32'(pulses - p_base), 32'd2);
    chk("rmw_mem_lo", 32'(mem[8'h00]), 32'hAB22);
    chk("rmw_mem_hi_untouched", 32'(mem[8'h01]), 32'h3344);
    idle_cycles(3);

    // 5: empty-strobe write completes without touching memory
    push_resp(1, 32'h0, 2);
    p_base = pulses;
    req(1, 1'b1, 18'h00005, 32'hFFFFFFFF, 4'b0000, 1'b1);
    chk("wr_empty_pulses", 32'(pulses - p_base), 32'd0);
    idle_cycles(3);

    // 4: both ports contend for four reads each
    for (int i = 0; i < 4; i++) begin
      mem[8'h80 + 2*i] = 16'(16'h1000 + i); mem[8'h81 + 2*i] = 16'(16'h2000 + i);
      mem[8'h90 + 2*i] = 16'(16'h3000 + i); mem[8'h91 + 2*i] = 16'(16'h4000 + i);
    end
`ifdef SRAM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      push_resp(0, {16'(16'h2000 + i), 16'(16'h1000 + i)}, -1);
      push_resp(1, {16'(16'h4000 + i), 16'(16'h3000 + i)}, -1);
    end
`else
    for (int i = 0; i < 4; i++) push_resp(0, {16'(16'h2000 + i), 16'(16'h1000 + i)}, -1);
    for (int i = 0; i < 4; i++) push_resp(1, {16'(16'h4000 + i), 16'(16'h3000 + i)}, -1);
`endif
    chk_cmd = 1'b0;
    fork
      begin for (int i = 0; i < 4; i++) req(0, 1'b0, 18'(18'h40 + i), 32'h0, 4'h0, i == 3); end
      begin for (int j = 0; j < 4; j++) req(1, 1'b0, 18'(18'h48 + j), 32'h0, 4'h0, j == 3); end
    join
    idle_cycles(3);
    chk_cmd = 1'b1;
    chk("contend_resp_drained", 32'(resp_q.size()), 32'h0);

    // 6: reset during WAIT of a read abandons it; a stray mem_ready follows
    push_cmd(1'b0, 19'h00020, 16'h0);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 18'h00010; p0_wstrb = 4'h0;
    idle_cycles(2);
    resetn = 1'b0;
    p0_valid = 1'b0;
    idle_cycles(1);
    resetn = 1'b1;
    chk_reset_outputs("midreset");
    idle_cycles(1);
    chk("stray_ready_present", 32'(mem_ready), 32'h1);
    chk("stray_ready_no_cmd", 32'(mem_valid), 32'h0);
    idle_cycles(1);
    chk("stray_ready_no_p0", 32'(p0_ready), 32'h0);
    chk("stray_ready_mem_valid", 32'(mem_valid), 32'h0);
    idle_cycles(2);
    push_cmd(1'b0, 19'h00020, 16'h0);
    push_cmd(1'b0, 19'h00021, 16'h0);
    push_resp(0, 32'hDEADBEEF, 9);
    req(0, 1'b0, 18'h00010, 32'h0, 4'h0, 1'b1);
    idle_cycles(4);

    chk("final_resp_queue", 32'(resp_q.size()), 32'h0);
    chk("final_cmd_queue", 32'(cmd_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
